// File: rtl/fll_cfg_responder_if.sv
// Configuration handshake bundle between the APB-side initiator and the FLL-side responder.
// The request and its qualifiers come from the initiator. The ack and read data come from the responder.
interface fll_cfg_responder_if;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_r_data;

  modport master (
    output fll_req, fll_wrn, fll_add, fll_data,
    input  fll_ack, fll_r_data
  );

  modport slave (
    input  fll_req, fll_wrn, fll_add, fll_data,
    output fll_ack, fll_r_data
  );
endinterface

// File: rtl/fll_cfg_responder.sv
// FLL-side responder for the 4-phase req/ack configuration handshake.
// It holds CFG1/CFG2, serves STATUS/INTEG and derives fll_lock with assert/deassert hysteresis.
module fll_cfg_responder #(
  parameter logic [31:0] CFG1_RESET  = 32'h4000_05F5,
  parameter logic [31:0] CFG2_RESET  = 32'h0010_0C41,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  fll_cfg_responder_if.slave   bus,
  output logic                 fll_lock,
  input  logic                 in_tol,
  input  logic [15:0]          mult_meas,
  input  logic [9:0]           integ_val,
  output logic [31:0]          cfg1,
  output logic [31:0]          cfg2,
  output logic                 integ_load,
  output logic [9:0]           integ_load_val
);

  localparam logic [31:0] CFG2_MASK = 32'h0FFF_FFFF;

  typedef enum logic {IDLE, ACK} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   access;
  logic                   ack_q;
  logic [31:0]            r_data_q;
  logic [31:0]            rd_mux;
  logic [5:0]             lock_cnt_q, lock_cnt_nxt;
  logic                   lock_q, lock_nxt;
  logic                   qual;
  logic [5:0]             thr;
  logic [6:0]             run_inc;

  // A zero threshold behaves like one: the first qualifying cycle is enough.
  function automatic logic [5:0] eff_thr(input logic [5:0] t);
    return (t == 6'd0) ? 6'd1 : t;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'h3F) ? c : c + 6'd1;
  endfunction

  // Request synchronizer into the reference clock domain
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) req_sync <= '0;
    else          req_sync <= {req_sync[SYNC_STAGES-2:0], bus.fll_req};
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state_q;
    access    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          access    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (bus.fll_add)
      2'd0:    rd_mux = {15'b0, lock_q, mult_meas};
      2'd1:    rd_mux = cfg1;
      2'd2:    rd_mux = cfg2;
      default: rd_mux = {6'b0, integ_val, 16'b0};
    endcase
  end

  // Access stage: the single read or write of a request happens on the IDLE->ACK edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= IDLE;
      ack_q          <= 1'b0;
      r_data_q       <= '0;
      cfg1           <= CFG1_RESET;
      cfg2           <= CFG2_RESET & CFG2_MASK;
      integ_load     <= 1'b0;
      integ_load_val <= '0;
    end else begin
      state_q    <= state_nxt;
      ack_q      <= (state_nxt == ACK);
      integ_load <= 1'b0;
      if (access) begin
        if (bus.fll_wrn) begin
          r_data_q <= rd_mux;
        end else begin
          case (bus.fll_add)
            2'd1: cfg1 <= bus.fll_data;
            2'd2: cfg2 <= bus.fll_data & CFG2_MASK;
            2'd3: begin
              integ_load     <= 1'b1;
              integ_load_val <= bus.fll_data[25:16];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.fll_ack    = ack_q;
  assign bus.fll_r_data = r_data_q;

  // Lock hysteresis: count consecutive cycles that argue for a state change
  always_comb begin
    lock_nxt     = lock_q;
    lock_cnt_nxt = lock_cnt_q;
    qual         = lock_q ? ~in_tol : in_tol;
    thr          = eff_thr(lock_q ? cfg2[9:4] : cfg2[15:10]);
    run_inc      = {1'b0, lock_cnt_q} + 7'd1;
    if (!cfg1[30]) begin
      lock_nxt     = 1'b0;
      lock_cnt_nxt = '0;
    end else if (!qual) begin
      lock_cnt_nxt = '0;
    end else if (run_inc >= {1'b0, thr}) begin
      lock_nxt     = ~lock_q;
      lock_cnt_nxt = '0;
    end else begin
      lock_cnt_nxt = sat_inc(lock_cnt_q);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_q     <= lock_nxt;
      lock_cnt_q <= lock_cnt_nxt;
    end
  end

  assign fll_lock = lock_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Self-checking bench for fll_cfg_responder: randomized register traffic and in_tol patterns
// compared against a behavioural register/lock model.
module tb_fll_cfg_responder;

  localparam logic [31:0] CFG1_RST = 32'h4000_05F5;
  localparam logic [31:0] CFG2_RST = 32'h0010_0C41;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        in_tol = 1'b0;
  logic [15:0] mult_meas = '0;
  logic [9:0]  integ_val = '0;
  logic        fll_lock;
  logic [31:0] cfg1, cfg2;
  logic        integ_load;
  logic [9:0]  integ_load_val;

  int tests = 0;
  int fails = 0;

  logic [31:0] cfg1_m, cfg2_m;
  logic        lock_m;
  int          run_m;
  int          load_cnt = 0;
  logic [9:0]  load_val_seen = '0;

  fll_cfg_responder_if bus();

  fll_cfg_responder dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .bus            (bus),
    .fll_lock       (fll_lock),
    .in_tol         (in_tol),
    .mult_meas      (mult_meas),
    .integ_val      (integ_val),
    .cfg1           (cfg1),
    .cfg2           (cfg2),
    .integ_load     (integ_load),
    .integ_load_val (integ_load_val)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (integ_load === 1'b1) begin
      load_cnt      = load_cnt + 1;
      load_val_seen = integ_load_val;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Lock reference: lock flips once the run of consecutive qualifying cycles reaches the threshold.
  task automatic model_step(input logic v);
    int t;
    if (!cfg1_m[30]) begin
      lock_m = 1'b0;
      run_m  = 0;
    end else begin
      t = lock_m ? int'(cfg2_m[9:4]) : int'(cfg2_m[15:10]);
      if (t == 0) t = 1;
      if (lock_m ? !v : v) begin
        run_m++;
        if (run_m >= t) begin
          lock_m = !lock_m;
          run_m  = 0;
        end
      end else begin
        run_m = 0;
      end
    end
  endtask

  task automatic do_access(input logic wrn, input logic [1:0] add, input logic [31:0] data,
                           output logic [31:0] rdata, output int rise, output int fall);
    @(posedge HCLK); #1;
    bus.fll_wrn  = wrn;
    bus.fll_add  = add;
    bus.fll_data = data;
    bus.fll_req  = 1'b1;
    rise = 0;
    while (bus.fll_ack !== 1'b1 && rise < 20) begin
      @(posedge HCLK); #1; rise++;
    end
    rdata = bus.fll_r_data;
    bus.fll_req = 1'b0;
    fall = 0;
    while (bus.fll_ack !== 1'b0 && fall < 20) begin
      @(posedge HCLK); #1; fall++;
    end
    if (rise >= 20 || fall >= 20) begin
      tests++; fails++;
      $display("FAIL handshake_timeout rise_edges=%0d fall_edges=%0d required both < 20", rise, fall);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int r, f;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    tests++; if (bus.fll_ack !== 1'b0) begin fails++; $display("FAIL rst_ack got=%b exp=0", bus.fll_ack); end
    tests++; if (fll_lock !== 1'b0) begin fails++; $display("FAIL rst_lock got=%b exp=0", fll_lock); end
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    tests++; if (cfg1 !== CFG1_RST) begin fails++; $display("FAIL rst_cfg1 got=%h exp=%h", cfg1, CFG1_RST); end
    tests++; if (cfg2 !== 32'h0010_0C41) begin fails++; $display("FAIL rst_cfg2 got=%h exp=00100c41", cfg2); end
    tests++; if (bus.fll_r_data !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", bus.fll_r_data); end
    tests++; if (integ_load !== 1'b0 || integ_load_val !== 10'h0) begin
      fails++; $display("FAIL rst_integ got=%b/%h exp=0/000", integ_load, integ_load_val);
    end
    cfg1_m = CFG1_RST;
    cfg2_m = CFG2_RST & 32'h0FFF_FFFF;
    lock_m = 1'b0;
    run_m  = 0;
    do_access(1'b1, 2'd1, 32'h0, rd, r, f);
    tests++; if (rd !== CFG1_RST) begin fails++; $display("FAIL rst_read_cfg1 got=%h exp=%h", rd, CFG1_RST); end
  endtask

  task automatic test_cfg1_handshake;
    logic [31:0] rd;
    int r, f;
    do_access(1'b0, 2'd1, 32'hDEAD_BEEF, rd, r, f);
    cfg1_m = 32'hDEAD_BEEF;
    tests++; if (r !== 3) begin fails++; $display("FAIL wr_ack_rise_edges got=%0d exp=3", r); end
    tests++; if (f !== 3) begin fails++; $display("FAIL wr_ack_fall_edges got=%0d exp=3", f); end
    tests++; if (cfg1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL cfg1_port got=%h exp=deadbeef", cfg1); end
    do_access(1'b1, 2'd1, 32'h0, rd, r, f);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_cfg1 got=%h exp=deadbeef", rd); end
    tests++; if (r !== 3 || f !== 3) begin fails++; $display("FAIL rd_ack_edges got=%0d/%0d exp=3/3", r, f); end
  endtask

  task automatic test_cfg_random;
    logic [31:0] rd, d, exp;
    logic [1:0]  a;
    int r, f;
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      d = $urandom;
      do_access(1'b0, a, d, rd, r, f);
      if (a == 2'd1) cfg1_m = d; else cfg2_m = d & 32'h0FFF_FFFF;
      do_access(1'b1, a, 32'h0, rd, r, f);
      exp = (a == 2'd1) ? cfg1_m : cfg2_m;
      tests++; if (rd !== exp) begin fails++; $display("FAIL rand_rw addr=%0d got=%h exp=%h", a, rd, exp); end
      tests++; if (cfg1 !== cfg1_m || cfg2 !== cfg2_m) begin
        fails++; $display("FAIL rand_ports got=%h/%h exp=%h/%h", cfg1, cfg2, cfg1_m, cfg2_m);
      end
    end
  endtask

  task automatic test_status;
    logic [31:0] rd, prev, exp;
    int r, f;
    mult_meas = 16'h05F5;
    do_access(1'b1, 2'd0, 32'h0, rd, r, f);
    tests++; if (rd !== 32'h0000_05F5) begin fails++; $display("FAIL status_read got=%h exp=000005f5", rd); end
    prev = rd;
    do_access(1'b0, 2'd0, 32'hFFFF_FFFF, rd, r, f);
    tests++; if (r !== 3) begin fails++; $display("FAIL status_wr_ack got=%0d exp=3", r); end
    tests++; if (bus.fll_r_data !== prev) begin fails++; $display("FAIL rdata_hold got=%h exp=%h", bus.fll_r_data, prev); end
    tests++; if (cfg1 !== cfg1_m || cfg2 !== cfg2_m) begin
      fails++; $display("FAIL status_wr_side got=%h/%h exp=%h/%h", cfg1, cfg2, cfg1_m, cfg2_m);
    end
    do_access(1'b1, 2'd0, 32'h0, rd, r, f);
    tests++; if (rd !== 32'h0000_05F5) begin fails++; $display("FAIL status_after_wr got=%h exp=000005f5", rd); end
    for (int i = 0; i < 4; i++) begin
      mult_meas = 16'($urandom);
      integ_val = 10'($urandom);
      do_access(1'b1, 2'd0, 32'h0, rd, r, f);
      exp = {15'b0, lock_m, mult_meas};
      tests++; if (rd !== exp) begin fails++; $display("FAIL status_rand got=%h exp=%h", rd, exp); end
      do_access(1'b1, 2'd3, 32'h0, rd, r, f);
      exp = {6'b0, integ_val, 16'b0};
      tests++; if (rd !== exp) begin fails++; $display("FAIL integ_read got=%h exp=%h", rd, exp); end
    end
  endtask

  task automatic test_integ_load;
    logic [31:0] d;
    int c0, n;
    d = $urandom;
    d[25:16] = 10'h155;
    c0 = load_cnt;
    @(posedge HCLK); #1;
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd3;
    bus.fll_data = d;
    bus.fll_req  = 1'b1;
    repeat (20) @(posedge HCLK);
    #1;
    tests++; if (bus.fll_ack !== 1'b1) begin fails++; $display("FAIL integ_ack_held got=%b exp=1", bus.fll_ack); end
    bus.fll_req = 1'b0;
    n = 0;
    while (bus.fll_ack !== 1'b0 && n < 20) begin @(posedge HCLK); #1; n++; end
    tests++; if (n !== 3) begin fails++; $display("FAIL integ_ack_fall got=%0d exp=3", n); end
    tests++; if (load_cnt - c0 !== 1) begin fails++; $display("FAIL integ_pulses got=%0d exp=1", load_cnt - c0); end
    tests++; if (load_val_seen !== 10'h155 || integ_load_val !== 10'h155) begin
      fails++; $display("FAIL integ_val got=%h/%h exp=155", load_val_seen, integ_load_val);
    end
    tests++; if (cfg1 !== cfg1_m || cfg2 !== cfg2_m) begin
      fails++; $display("FAIL integ_side got=%h/%h exp=%h/%h", cfg1, cfg2, cfg1_m, cfg2_m);
    end
  endtask

  task automatic setup_lock(input logic [5:0] as_c, input logic [5:0] de_c);
    logic [31:0] rd, d;
    int r, f;
    in_tol = 1'b0;
    d = $urandom; d[30] = 1'b0;
    do_access(1'b0, 2'd1, d, rd, r, f);
    cfg1_m = d;
    d = $urandom; d[15:10] = as_c; d[9:4] = de_c;
    do_access(1'b0, 2'd2, d, rd, r, f);
    cfg2_m = d & 32'h0FFF_FFFF;
    d = $urandom; d[30] = 1'b1;
    do_access(1'b0, 2'd1, d, rd, r, f);
    cfg1_m = d;
    lock_m = 1'b0;
    run_m  = 0;
  endtask

  task automatic test_lock_plan;
    logic seq [13] = '{1,1,1,0, 1,1,1,1, 1,1, 0,0, 0};
    logic exp [13] = '{0,0,0,0, 0,0,0,1, 1,1, 1,0, 0};
    setup_lock(6'd4, 6'd2);
    tests++; if (fll_lock !== 1'b0) begin fails++; $display("FAIL lock_start got=%b exp=0", fll_lock); end
    for (int i = 0; i < 13; i++) begin
      in_tol = seq[i];
      @(posedge HCLK); #1;
      tests++; if (fll_lock !== exp[i]) begin
        fails++; $display("FAIL lock_plan step=%0d got=%b exp=%b", i, fll_lock, exp[i]);
      end
    end
    in_tol = 1'b0;
  endtask

  task automatic test_lock_random;
    logic v;
    for (int k = 0; k < 4; k++) begin
      setup_lock(6'($urandom_range(0, 5)), 6'($urandom_range(0, 5)));
      for (int i = 0; i < 60; i++) begin
        v = ($urandom_range(0, 9) < 7) ? !lock_m : lock_m;
        in_tol = v;
        @(posedge HCLK);
        model_step(v);
        #1;
        tests++; if (fll_lock !== lock_m) begin
          fails++; $display("FAIL lock_rand round=%0d cyc=%0d got=%b exp=%b", k, i, fll_lock, lock_m);
        end
      end
    end
    in_tol = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int c0, c1, n;
    in_tol = 1'b0;
    d = $urandom;
    c0 = load_cnt;
    @(posedge HCLK); #1;
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd3;
    bus.fll_data = d;
    bus.fll_req  = 1'b1;
    n = 0;
    while (bus.fll_ack !== 1'b1 && n < 20) begin @(posedge HCLK); #1; n++; end
    tests++; if (n !== 3) begin fails++; $display("FAIL mid_first_ack got=%0d exp=3", n); end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b0;
    #1;
    tests++; if (bus.fll_ack !== 1'b0) begin fails++; $display("FAIL mid_ack_async got=%b exp=0", bus.fll_ack); end
    tests++; if (cfg1 !== CFG1_RST || integ_load_val !== 10'h0) begin
      fails++; $display("FAIL mid_rst_state got=%h/%h exp=%h/000", cfg1, integ_load_val, CFG1_RST);
    end
    c1 = load_cnt;
    tests++; if (c1 - c0 !== 1) begin fails++; $display("FAIL mid_first_pulse got=%0d exp=1", c1 - c0); end
    cfg1_m = CFG1_RST;
    cfg2_m = CFG2_RST & 32'h0FFF_FFFF;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    n = 0;
    while (bus.fll_ack !== 1'b1 && n < 20) begin @(posedge HCLK); #1; n++; end
    tests++; if (n !== 3) begin fails++; $display("FAIL mid_reack got=%0d exp=3", n); end
    repeat (10) @(posedge HCLK);
    #1;
    bus.fll_req = 1'b0;
    n = 0;
    while (bus.fll_ack !== 1'b0 && n < 20) begin @(posedge HCLK); #1; n++; end
    tests++; if (load_cnt - c1 !== 1) begin fails++; $display("FAIL mid_reexec_pulses got=%0d exp=1", load_cnt - c1); end
    tests++; if (integ_load_val !== d[25:16]) begin
      fails++; $display("FAIL mid_reexec_val got=%h exp=%h", integ_load_val, d[25:16]);
    end
    tests++; if (cfg1 !== cfg1_m || cfg2 !== cfg2_m) begin
      fails++; $display("FAIL mid_cfg got=%h/%h exp=%h/%h", cfg1, cfg2, cfg1_m, cfg2_m);
    end
  endtask

  initial begin
    bus.fll_req  = 1'b0;
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd0;
    bus.fll_data = 32'h0;
    test_reset();
    test_cfg1_handshake();
    test_cfg_random();
    test_status();
    test_integ_load();
    test_lock_plan();
    test_lock_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fll_cfg_responder.md
Name: fll_cfg_responder

Overview:
FLL-side responder for the 4-phase req/ack configuration handshake driven by the APB FLL interface (fllN_req/wrn/add/data/ack/r_data/lock). It runs in the FLL reference clock domain and synchronizes the incoming request. It holds the FLL configuration registers and executes reads and writes. It also generates the lock indication from a per-cycle in-tolerance flag, using programmable assert and deassert hysteresis.

Parameters:
CFG1_RESET, 32'h4000_05F5, reset value of CFG1 (addr 1).
CFG2_RESET, 32'h0010_0C41, reset value of CFG2 (addr 2).
SYNC_STAGES, 2, flops on fll_req before FSM use (>=2).

Ports:
HCLK  input  1  FLL reference clock
HRESETn  input  1  async active-low reset
fll_req  input  1  request from initiator (async, 4-phase)
fll_wrn  input  1  1=read, 0=write; stable while fll_req high
fll_add  input  2  register address; stable while fll_req high
fll_data  input  32  write data; stable while fll_req high
fll_ack  output  1  acknowledge, registered
fll_r_data  output  32  read data, registered
fll_lock  output  1  lock indication, registered
in_tol  input  1  loop comparator: measured freq within tolerance this cycle
mult_meas  input  16  measured multiplication factor
integ_val  input  10  current integrator value
cfg1  output  32  CFG1 register contents
cfg2  output  32  CFG2 register contents
integ_load  output  1  one-cycle pulse on write to addr 3
integ_load_val  output  10  value to load, valid with integ_load

Behaviour:
- Register map:
  - addr0 STATUS (RO): {15'b0, fll_lock, mult_meas}. Writes are acked and discarded.
  - addr1 CFG1 (RW, 32 bits). [30] lock_en.
  - addr2 CFG2 (RW). [9:4] deassert_cyc, [15:10] assert_cyc. [31:28] read 0, writes ignored.
  - addr3 INTEG: read returns {6'b0, integ_val, 16'b0}. Write pulses integ_load with integ_load_val = fll_data[25:16].
- Reset values: fll_ack=0, fll_r_data=0, fll_lock=0, integ_load=0, integ_load_val=0, cfg1=CFG1_RESET, cfg2=CFG2_RESET & 32'h0FFF_FFFF. Sync flops=0, FSM=IDLE, lock counter=0.
- req_s = fll_req after SYNC_STAGES flops.
- FSM states IDLE, ACK, with transitions:
  - IDLE & req_s: sample fll_wrn/fll_add/fll_data this cycle and perform the access on this edge. Write: register updated; for addr3, integ_load=1 next cycle only. Read: fll_r_data loaded. Go to ACK with fll_ack=1.
  - ACK & req_s: stay, ack=1, no further access.
  - ACK & !req_s: fll_ack=0, go to IDLE.
  - IDLE & !req_s: idle, ack=0.
- Latency: fll_req rise at edge N gives fll_ack=1 after edge N+SYNC_STAGES+1. ack fall occurs SYNC_STAGES+1 edges after req fall.
- Exactly one access per req pulse. fll_r_data holds its value until the next read; writes do not change it.
- Lock detector:
  - lock_en=0: fll_lock=0 and counter=0.
  - Unlocked: counter increments on in_tol=1 and clears on in_tol=0. When counter+1 >= max(assert_cyc,1) with in_tol=1, fll_lock=1 next edge and counter clears.
  - Locked: the same rule applies with !in_tol and deassert_cyc, leading to fll_lock=0.
  - The counter is 6-bit and saturating.
  - A threshold change via write takes effect from the next cycle. Counter >= new threshold triggers immediately.
- Reset mid-handshake: all state returns to reset values, ack drops asynchronously. If fll_req is still high after release, it is treated as a new request (one access).
- Simultaneous CFG write and lock evaluation in the same cycle: lock uses the old CFG values.

Test Plan:
- Reset release -> cfg1=CFG1_RESET, cfg2=32'h0010_0C41, fll_ack=0, fll_lock=0. Read addr1 -> fll_r_data=CFG1_RESET.
- Write addr1 = 32'hDEAD_BEEF via full handshake, then read addr1 -> 32'hDEAD_BEEF. Check ack rise 3 edges after req rise and fall 3 edges after req fall.
- mult_meas=16'h05F5, lock=0, read addr0 -> 32'h0000_05F5. Write addr0 = 32'hFFFF_FFFF -> acked, addr0 read unchanged.
- Write addr3 with data[25:16]=10'h155 -> integ_load high exactly 1 cycle, integ_load_val=10'h155. Holding req high 20 cycles -> only one pulse.
- lock_en=1, assert_cyc=4, deassert_cyc=2, in_tol held 1 -> fll_lock=1 after 4th in-tol cycle. A 3-cycle burst then in_tol=0 for 1 cycle -> no assert. in_tol=0 for 2 cycles while locked -> fll_lock=0.
- Assert HRESETn low while fll_ack=1 with fll_req held high, then release -> ack=0 during reset. After release the request is re-executed exactly once and ack re-asserts after 3 edges.
